// File: rtl/vga_pkg.sv
// Shared VGA definitions: default raster sizes, RGB565 layout and colours,
// and the line-buffer write-FSM state encoding.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;
  localparam int RGB_W   = RGB_R_W + RGB_G_W + RGB_B_W;

  localparam logic [RGB_W-1:0] RGB_BLACK  = 16'h0000;
  localparam logic [RGB_W-1:0] RGB_YELLOW = 16'hFFE0;

  typedef enum logic [1:0] {
    WR_SYNC = 2'd0,
    WR_FILL = 2'd1,
    WR_WAIT = 2'd2
  } wr_state_e;

endpackage

// File: rtl/vga_line_ram.sv
// Simple dual-port line RAM: one write port, one registered read port.
module vga_line_ram #(
  parameter int DEPTH = 640,
  parameter int DW    = 16,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vga_line_buffer.sv
// Ping-pong line buffer between a bursty RGB565 pixel source and the VGA
// timing stage. Two banks each hold one active line; one pixel out per request.
module vga_line_buffer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int DW       = 16,
  parameter int AW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  // Source handshake: a pixel transfers on a clk edge where s_valid and
  // s_ready are both high; s_ready is registered and never looks at s_valid.
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_sof,
  input  logic          disp_frame_start,
  input  logic          disp_line_start,
  input  logic          disp_pix_en,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  output logic          underrun,
  output logic [1:0]    lines_full
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(H_ACTIVE - 1);

  wr_state_e     state_q, state_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]    full_q, full_d;
  logic          rd_armed_q, rd_armed_d;
  logic          s_ready_q, s_ready_d;
  logic          pix_valid_q, pix_valid_d;
  logic          rd_src_q, rd_src_d;
  logic          rd_sel_q, rd_sel_d;
  logic          underrun_q, underrun_d;

  logic          hs;
  logic          restart;
  logic          rd_fire;
  logic [1:0]    we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] rdata0, rdata1;

  always_comb begin
    hs      = s_valid & s_ready_q;
    restart = hs & s_sof;
    rd_fire = disp_pix_en & rd_armed_q & ~disp_frame_start & ~restart;

    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    full_d      = full_q;
    rd_armed_d  = rd_armed_q;
    underrun_d  = underrun_q;
    pix_valid_d = disp_pix_en;
    rd_src_d    = rd_fire;
    rd_sel_d    = rd_bank_q;
    we          = 2'b00;
    ram_waddr   = wr_addr_q;

    if (rd_fire) begin
      if (rd_addr_q == LAST_ADDR) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_addr_d         = '0;
        rd_armed_d        = 1'b0;
      end else begin
        rd_addr_d = rd_addr_q + AW'(1);
      end
    end

    if (disp_frame_start) begin
      full_d     = 2'b00;
      rd_bank_d  = 1'b0;
      wr_bank_d  = 1'b0;
      wr_addr_d  = '0;
      rd_armed_d = 1'b0;
      state_d    = WR_SYNC;
    end

    // Any accepted start-of-frame pixel (first sync or early) restarts both banks.
    if (restart) begin
      full_d     = 2'b00;
      rd_bank_d  = 1'b0;
      wr_bank_d  = 1'b0;
      rd_armed_d = 1'b0;
      we[0]      = 1'b1;
      ram_waddr  = '0;
      wr_addr_d  = AW'(1);
      state_d    = WR_FILL;
    end else if (!disp_frame_start) begin
      case (state_q)
        WR_FILL: begin
          if (hs) begin
            we[wr_bank_q] = 1'b1;
            if (wr_addr_q == LAST_ADDR) begin
              full_d[wr_bank_q] = 1'b1;
              wr_bank_d         = ~wr_bank_q;
              wr_addr_d         = '0;
              state_d           = full_d[~wr_bank_q] ? WR_WAIT : WR_FILL;
            end else begin
              wr_addr_d = wr_addr_q + AW'(1);
            end
          end
        end
        WR_WAIT: begin
          if (!full_q[wr_bank_q]) begin
            state_d = WR_FILL;
          end
        end
        default: ;
      endcase
    end

    if (disp_line_start) begin
      if (full_q[rd_bank_q] && !disp_frame_start && !restart) begin
        rd_armed_d = 1'b1;
        rd_addr_d  = '0;
      end else begin
        rd_armed_d = 1'b0;
        underrun_d = 1'b1;
      end
    end

    s_ready_d = (state_d != WR_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WR_SYNC;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      full_q      <= 2'b00;
      rd_armed_q  <= 1'b0;
      s_ready_q   <= 1'b0;
      pix_valid_q <= 1'b0;
      rd_src_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      full_q      <= full_d;
      rd_armed_q  <= rd_armed_d;
      s_ready_q   <= s_ready_d;
      pix_valid_q <= pix_valid_d;
      rd_src_q    <= rd_src_d;
      rd_sel_q    <= rd_sel_d;
      underrun_q  <= underrun_d;
    end
  end

  vga_line_ram #(.DEPTH(H_ACTIVE), .DW(DW), .AW(AW)) u_ram0 (
    .clk   (clk),
    .we    (we[0]),
    .waddr (ram_waddr),
    .wdata (s_data),
    .raddr (rd_addr_q),
    .rdata (rdata0)
  );

  vga_line_ram #(.DEPTH(H_ACTIVE), .DW(DW), .AW(AW)) u_ram1 (
    .clk   (clk),
    .we    (we[1]),
    .waddr (ram_waddr),
    .wdata (s_data),
    .raddr (rd_addr_q),
    .rdata (rdata1)
  );

  // Unarmed or underrun requests return black rather than stale RAM output.
  assign pix_data   = rd_src_q ? (rd_sel_q ? rdata1 : rdata0) : '0;
  assign pix_valid  = pix_valid_q;
  assign s_ready    = s_ready_q;
  assign underrun   = underrun_q;
  assign lines_full = full_q;

endmodule
